// File: rtl/keypad_pkg.sv
// Keypad event controller shared types.
// Key count, event record and scan FSM states.
package keypad_pkg;

    localparam int KEY_COUNT  = 12;
    localparam int KEY_CODE_W = 4;

    typedef struct packed {
        logic [KEY_CODE_W-1:0] code;
        logic                  press;
    } key_event_t;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } scan_state_t;

endpackage

// File: rtl/keypad_event_fifo.sv
// Keypad event queue.
// Power-of-two depth, push accepted when full only alongside a pop.
module keypad_event_fifo
    import keypad_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          push_i,
    input  key_event_t    data_i,
    input  logic          pop_i,
    output key_event_t    data_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [CW-1:0] count_o
);

    logic [AW-1:0] wptr_q;
    logic [AW-1:0] rptr_q;
    logic [CW-1:0] cnt_q;
    key_event_t    mem_q [DEPTH];
    logic          wr_en;
    logic          rd_en;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CW'(DEPTH));
    assign count_o = cnt_q;
    assign data_o  = mem_q[rptr_q];
    assign rd_en   = pop_i && !empty_o;
    assign wr_en   = push_i && (!full_o || rd_en);

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (wr_en) wptr_q <= wptr_q + 1'b1;
            if (rd_en) rptr_q <= rptr_q + 1'b1;
            if (wr_en && !rd_en) cnt_q <= cnt_q + 1'b1;
            else if (rd_en && !wr_en) cnt_q <= cnt_q - 1'b1;
        end
    end

    // Storage, cleared so the head reads zero out of reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (wr_en) begin
            mem_q[wptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/keypad_event_ctrl.sv
// Keypad debouncer and press/release event generator.
// Tick divider, per-key debounce, scan FSM feeding the event FIFO.
module keypad_event_ctrl
    import keypad_pkg::*;
#(
    parameter int DIVIDER      = 8192,
    parameter int COUNTER_BITS = 13,
    parameter int DEBOUNCE     = 3,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                  clk_3p33MHz,
    input  logic                  reset_n,
    input  logic [KEY_COUNT-1:0]  keypad_button,
    output logic                  event_valid,
    input  logic                  event_ready,
    output logic [KEY_CODE_W-1:0] event_code,
    output logic                  event_press,
    output logic [2:0]            event_count,
    output logic                  overflow,
    input  logic                  overflow_clr
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [COUNTER_BITS-1:0]     div_q;
    logic                        tick;
    logic [KEY_COUNT-1:0]        state_q, state_d;
    logic [KEY_COUNT-1:0]        pend_q, pend_d;
    logic [KEY_COUNT-1:0][2:0]   dcnt_q, dcnt_d;
    scan_state_t                 st_q, st_d;
    logic [KEY_CODE_W-1:0]       idx_q, idx_d;
    logic                        ovf_q, ovf_d;
    logic                        push, pop, drop;
    logic                        full, empty;
    logic [CW-1:0]               fifo_cnt;
    key_event_t                  push_ev, head;

    assign tick = (div_q == COUNTER_BITS'(DIVIDER - 1));

    // Free-running sample tick divider.
    always_ff @(posedge clk_3p33MHz or negedge reset_n) begin
        if (!reset_n) div_q <= '0;
        else if (tick) div_q <= '0;
        else div_q <= div_q + 1'b1;
    end

    assign push         = (st_q == ST_SCAN) && pend_q[idx_q];
    assign pop          = event_valid && event_ready;
    assign drop         = push && full && !pop;
    assign push_ev.code  = idx_q;
    assign push_ev.press = state_q[idx_q];

    // Debounce counters, debounced levels and pending-change flags.
    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        dcnt_d  = dcnt_q;
        if (push) pend_d[idx_q] = 1'b0;
        if (tick) begin
            for (int i = 0; i < KEY_COUNT; i++) begin
                if (keypad_button[i] != state_q[i]) begin
                    if (dcnt_q[i] == 3'(DEBOUNCE - 1)) begin
                        state_d[i] = ~state_q[i];
                        dcnt_d[i]  = '0;
                        pend_d[i]  = 1'b1;
                    end else begin
                        dcnt_d[i] = dcnt_q[i] + 1'b1;
                    end
                end else begin
                    dcnt_d[i] = '0;
                end
            end
        end
    end

    // Scan FSM walks every key once after each tick.
    always_comb begin
        st_d  = st_q;
        idx_d = idx_q;
        unique case (1'b1)
            (st_q == ST_IDLE): begin
                if (tick) begin
                    st_d  = ST_SCAN;
                    idx_d = '0;
                end
            end
            (st_q == ST_SCAN): begin
                if (idx_q == KEY_CODE_W'(KEY_COUNT - 1)) begin
                    st_d  = ST_IDLE;
                    idx_d = '0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: begin
                st_d  = ST_IDLE;
                idx_d = '0;
            end
        endcase
    end

    // Sticky overflow, a drop outranks the clear.
    always_comb begin
        ovf_d = ovf_q;
        if (drop) ovf_d = 1'b1;
        else if (overflow_clr) ovf_d = 1'b0;
    end

    // Key, scan and overflow state registers.
    always_ff @(posedge clk_3p33MHz or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= '0;
            pend_q  <= '0;
            dcnt_q  <= '0;
            st_q    <= ST_IDLE;
            idx_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            dcnt_q  <= dcnt_d;
            st_q    <= st_d;
            idx_q   <= idx_d;
            ovf_q   <= ovf_d;
        end
    end

    keypad_event_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_3p33MHz),
        .rst_ni  (reset_n),
        .push_i  (push),
        .data_i  (push_ev),
        .pop_i   (pop),
        .data_o  (head),
        .full_o  (full),
        .empty_o (empty),
        .count_o (fifo_cnt)
    );

    assign event_valid = !empty;
    assign event_code  = head.code;
    assign event_press = head.press;
    assign event_count = 3'(fifo_cnt);
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_keypad_event_ctrl.sv
// Testbench for keypad_event_ctrl.
// Directed scenarios plus random keys/ready against a queue-based model.
module tb_keypad_event_ctrl;
    import keypad_pkg::*;

    localparam int DIV   = 16;
    localparam int DB    = 3;
    localparam int DEPTH = 4;
    localparam int NK    = 12;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [11:0] keys = '0;
    logic        ready = 1'b0;
    logic        clr = 1'b0;
    logic        event_valid;
    logic [3:0]  event_code;
    logic        event_press;
    logic [2:0]  event_count;
    logic        overflow;

    always #5 clk = ~clk;

    keypad_event_ctrl #(
        .DIVIDER      (DIV),
        .COUNTER_BITS (13),
        .DEBOUNCE     (DB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk_3p33MHz   (clk),
        .reset_n       (reset_n),
        .keypad_button (keys),
        .event_valid   (event_valid),
        .event_ready   (ready),
        .event_code    (event_code),
        .event_press   (event_press),
        .event_count   (event_count),
        .overflow      (overflow),
        .overflow_clr  (clr)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int npops    = 0;

    task automatic chk(string name, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: key levels, debounce counts, scheduled pushes, queue.
    int   cyc;
    bit   mst [NK];
    int   mcnt [NK];
    int   push_at [NK];
    bit   mtog [NK];
    int   mq [$];
    int   exp_q [$];
    bit   movf;
    bit   m_pop, m_have;
    int   m_ev;
    event tick_ev;

    initial begin
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                cyc  = 0;
                movf = 0;
                mq.delete();
                exp_q.delete();
                for (int k = 0; k < NK; k++) begin
                    mst[k] = 0; mcnt[k] = 0; push_at[k] = -1; mtog[k] = 0;
                end
            end else begin
                m_pop  = (mq.size() > 0) && ready;
                m_have = 0;
                m_ev   = 0;
                for (int k = 0; k < NK; k++) begin
                    if (push_at[k] == cyc) begin
                        m_have = 1;
                        m_ev = k * 2 + int'(mst[k]);
                        push_at[k] = -1;
                    end
                end
                if (m_pop) void'(mq.pop_front());
                if (m_have && mq.size() >= DEPTH) movf = 1;
                else if (clr) movf = 0;
                if (m_have && mq.size() < DEPTH) begin
                    mq.push_back(m_ev);
                    exp_q.push_back(m_ev);
                end
                if (cyc % DIV == DIV - 1) begin
                    for (int k = 0; k < NK; k++) begin
                        mtog[k] = 0;
                        if (keys[k] != mst[k]) begin
                            mcnt[k]++;
                            if (mcnt[k] == DB) begin
                                mst[k] = !mst[k];
                                mcnt[k] = 0;
                                mtog[k] = 1;
                                push_at[k] = cyc + 1 + k;
                            end
                        end else begin
                            mcnt[k] = 0;
                        end
                    end
                    -> tick_ev;
                end
                cyc++;
            end
        end
    end

    // Monitor: compare occupancy, flags and the presented head event.
    initial begin
        int e;
        forever begin
            @(negedge clk);
            if (reset_n) begin
                chk("count", int'(event_count), mq.size());
                chk("overflow", int'(overflow), int'(movf));
                chk("valid", int'(event_valid), int'(mq.size() != 0));
                if (event_valid) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_event: code %0d press %0d at %0t",
                                 event_code, event_press, $time);
                    end else begin
                        e = exp_q[0];
                        chk("code", int'(event_code), e / 2);
                        chk("press", int'(event_press), e % 2);
                        if (ready) begin
                            void'(exp_q.pop_front());
                            npops++;
                        end
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic wait_ticks(int n);
        repeat (n * DIV) @(posedge clk);
        #2;
    endtask

    task automatic wait_toggle(int k, output bit ok);
        ok = 0;
        for (int i = 0; i < 8 && !ok; i++) begin
            @(tick_ev);
            if (mtog[k]) ok = 1;
        end
    endtask

    int p0;
    bit ok;
    int hold;
    int rdy_pct;

    initial begin
        reset_n = 0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_valid", int'(event_valid), 0);
        chk("rst_code", int'(event_code), 0);
        chk("rst_press", int'(event_press), 0);
        chk("rst_count", int'(event_count), 0);
        chk("rst_overflow", int'(overflow), 0);
        reset_n = 1;

        // key 5 press then release
        ready = 1;
        p0 = npops;
        keys = 12'h020;
        wait_ticks(5);
        chk("k5_press_events", npops - p0, 1);
        keys = 12'h000;
        wait_ticks(5);
        chk("k5_release_events", npops - p0, 2);
        chk("k5_count_zero", int'(event_count), 0);

        // bouncing key 2 never settles
        p0 = npops;
        for (int i = 0; i < 10; i++) begin
            @(tick_ev);
            #2 keys[2] = ~keys[2];
        end
        wait_ticks(4);
        chk("bounce_events", npops - p0, 0);
        chk("bounce_overflow", int'(overflow), 0);

        // three keys queued in index order
        ready = 0;
        keys = 12'h809;
        wait_ticks(5);
        chk("multi_count", int'(event_count), 3);
        chk("multi_head", int'(event_code), 0);
        p0 = npops;
        ready = 1;
        wait_ticks(1);
        chk("multi_pops", npops - p0, 3);
        keys = 12'h000;
        wait_ticks(5);

        // five changes into a four-deep queue
        ready = 0;
        keys = 12'h552;
        wait_ticks(5);
        chk("ovf_count", int'(event_count), 4);
        chk("ovf_set", int'(overflow), 1);
        clr = 1;
        @(posedge clk);
        #2 clr = 0;
        chk("ovf_cleared", int'(overflow), 0);
        ready = 1;
        wait_ticks(1);

        // full queue, pop coincides with a push
        ready = 0;
        keys = 12'h400;
        wait_ticks(5);
        chk("full_count", int'(event_count), 4);
        keys = 12'h480;
        wait_toggle(7, ok);
        chk("k7_toggle_seen", int'(ok), 1);
        repeat (7) @(posedge clk);
        #2 ready = 1;
        @(posedge clk);
        #2 ready = 0;
        chk("full_pushpop_count", int'(event_count), 4);
        chk("full_pushpop_ovf", int'(overflow), 0);
        ready = 1;
        wait_ticks(1);
        keys = 12'h000;
        wait_ticks(5);

        // reset in the middle of a scan with two queued events
        ready = 0;
        keys = 12'h204;
        wait_toggle(9, ok);
        chk("k9_toggle_seen", int'(ok), 1);
        repeat (11) @(posedge clk);
        #2;
        chk("pre_reset_count", int'(event_count), 2);
        reset_n = 0;
        keys = 12'h000;
        #1;
        chk("midscan_rst_valid", int'(event_valid), 0);
        chk("midscan_rst_count", int'(event_count), 0);
        repeat (3) @(posedge clk);
        #2 reset_n = 1;
        ready = 1;
        p0 = npops;
        wait_ticks(6);
        chk("post_reset_events", npops - p0, 0);
        chk("post_reset_count", int'(event_count), 0);

        // random keys, ready and clears
        for (int r = 0; r < 60; r++) begin
            keys = keys ^ (12'($urandom) & 12'($urandom) & 12'($urandom));
            hold = (r % 3 == 0) ? $urandom_range(4, 30) : $urandom_range(40, 90);
            rdy_pct = (r % 2 == 0) ? 15 : 85;
            repeat (hold) begin
                @(posedge clk);
                #2;
                ready = ($urandom_range(0, 99) < rdy_pct);
                clr = ($urandom_range(0, 39) == 0);
            end
        end
        clr = 0;
        ready = 1;
        wait_ticks(6);
        chk("final_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/keypad_event_ctrl.md
KEYPAD_EVENT_CTRL -- requirements
Module: keypad_event_ctrl

Interface
REQ-001 SHALL have parameter DIVIDER, default 8192, clk_3p33MHz cycles per sample tick.
REQ-002 SHALL have parameter COUNTER_BITS, default 13, width of the tick divider counter.
REQ-003 SHALL have parameter DEBOUNCE, default 3, consecutive equal samples required to accept a key state change (legal range 1..7).
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, event queue entries (power of two).
REQ-005 SHALL have clk_3p33MHz  input  1  sole clock, all logic on its rising edge.
REQ-006 SHALL have reset_n  input  1  asynchronous, active-low reset.
REQ-007 SHALL have keypad_button  input  12  raw per-key level from the keypad scanner, 1 = pressed.
REQ-008 SHALL have event_valid  output  1  FIFO head holds an event.
REQ-009 SHALL have event_ready  input  1  consumer accepts the head event.
REQ-010 SHALL have event_code  output  4  key index 0..11 of the head event.
REQ-011 SHALL have event_press  output  1  head event type, 1 = press, 0 = release.
REQ-012 SHALL have event_count  output  3  FIFO occupancy, 0..FIFO_DEPTH.
REQ-013 SHALL have overflow  output  1  sticky flag, an event was dropped.
REQ-014 SHALL have overflow_clr  input  1  synchronous clear of overflow.

Function
REQ-015 Tick divider SHALL count 0..DIVIDER-1 and assert an internal one-cycle tick on the cycle it wraps to 0; first tick DIVIDER cycles after reset release.
REQ-016 On tick, every key SHALL sample keypad_button[i]; a sample differing from the debounced state increments that key's counter, an equal sample clears it.
REQ-017 When a key's counter reaches DEBOUNCE, the debounced state SHALL toggle, the counter SHALL clear, and the key's pending-change flag SHALL set.
REQ-018 Scan FSM states: IDLE, SCAN; IDLE -> SCAN on the cycle after tick; SCAN visits index 0..11, one per cycle, then returns to IDLE (12 cycles in SCAN).
REQ-019 In SCAN, a key with pending-change set SHALL push {index, debounced state} into the FIFO and clear its flag in the same cycle; lowest index is enqueued first.
REQ-020 Pushes to a full FIFO SHALL be dropped, the flag still cleared, and overflow set, unless a pop occurs in the same cycle, in which case the push SHALL be accepted.
REQ-021 Pop SHALL occur on a cycle with event_valid and event_ready both 1; event_code/event_press SHALL hold stable while event_valid=1 and event_ready=0.
REQ-022 Push into an empty FIFO SHALL raise event_valid on the following cycle (no same-cycle bypass).
REQ-023 Simultaneous push and pop SHALL leave event_count unchanged.
REQ-024 overflow_clr SHALL clear overflow, but a drop in the same cycle SHALL win (overflow stays 1).
REQ-025 A tick arriving while in SCAN is impossible for DIVIDER >= 16; DIVIDER < 16 is unsupported.
REQ-026 Read/write pointers SHALL wrap modulo FIFO_DEPTH; event_count SHALL never exceed FIFO_DEPTH.

Reset
REQ-027 reset_n low SHALL asynchronously force: divider 0, FSM IDLE, all debounced states 0, counters 0, pending flags 0, FIFO empty.
REQ-028 Outputs during reset SHALL be event_valid=0, event_code=0, event_press=0, event_count=0, overflow=0.
REQ-029 Reset asserted mid-SCAN or with a full FIFO SHALL discard all queued and pending events; no event SHALL emerge after release until a new debounced change.

Structure
REQ-030 Package keypad_pkg SHALL hold KEY_COUNT=12, KEY_CODE_W=4, the event record (code, press) and the FSM state enumeration.
REQ-031 The FIFO SHALL be a separate sub-module keypad_event_fifo (push/pop, full/empty, count, async active-low reset); divider, debounce and FSM stay in keypad_event_ctrl.

Verification (DIVIDER=16, DEBOUNCE=3)
REQ-032 Hold key 5 pressed for 3 ticks -> one event code=5 press=1; release for 3 ticks -> code=5 press=0; count returns to 0 after pops.
REQ-033 Toggle key 2 every tick for 10 ticks -> no event; overflow=0.
REQ-034 Press keys 0,3,11 together, event_ready=0 -> 3 events queued in order 0,3,11; count=3.
REQ-035 event_ready=0, change 5 keys simultaneously -> count=4, fifth (highest index) dropped, overflow=1; overflow_clr pulse -> overflow=0.
REQ-036 FIFO full with event_ready=1 during SCAN push -> push accepted, count stays 4, overflow=0.
REQ-037 Assert reset_n=0 mid-SCAN with count=2 -> event_valid=0, count=0 immediately; no events after release with keys held constant at 0.
